// File: rtl/clint_if.sv
// Bundle of X-stage, CSR-file and ctrl-facing signals around the core-local trap controller.
// slave is the controller's view; master is the driver's (pipeline/testbench) view.
interface clint_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
);
  logic              i_x_vld;
  logic [XLEN-1:0]   i_x_pc;
  logic              i_x_is_ecall;
  logic              i_x_is_ebreak;
  logic              i_x_is_mret;
  logic              i_x_branch_taken;
  logic [XLEN-1:0]   i_x_branch_addr;
  logic              i_irq_timer;
  logic              i_jtag_halt;
  logic              i_bus_mem_halt;
  logic [XLEN-1:0]   i_csr_mtvec;
  logic [XLEN-1:0]   i_csr_mepc;
  logic [XLEN-1:0]   i_csr_mstatus;
  logic [XLEN-1:0]   i_csr_mie;
  logic              o_csr_wr_en;
  logic [CSR_AW-1:0] o_csr_wr_addr;
  logic [XLEN-1:0]   o_csr_wr_data;
  logic              o_clint_stall;
  logic              o_clint_assert;
  logic [XLEN-1:0]   o_clint_assert_addr;

  modport slave (
    input  i_x_vld, i_x_pc, i_x_is_ecall, i_x_is_ebreak, i_x_is_mret,
    input  i_x_branch_taken, i_x_branch_addr, i_irq_timer, i_jtag_halt, i_bus_mem_halt,
    input  i_csr_mtvec, i_csr_mepc, i_csr_mstatus, i_csr_mie,
    output o_csr_wr_en, o_csr_wr_addr, o_csr_wr_data,
    output o_clint_stall, o_clint_assert, o_clint_assert_addr
  );

  modport master (
    output i_x_vld, i_x_pc, i_x_is_ecall, i_x_is_ebreak, i_x_is_mret,
    output i_x_branch_taken, i_x_branch_addr, i_irq_timer, i_jtag_halt, i_bus_mem_halt,
    output i_csr_mtvec, i_csr_mepc, i_csr_mstatus, i_csr_mie,
    input  o_csr_wr_en, o_csr_wr_addr, o_csr_wr_data,
    input  o_clint_stall, o_clint_assert, o_clint_assert_addr
  );
endinterface

// File: rtl/clint.sv
// Core-local trap controller: detects ecall/ebreak/mret/timer IRQ in X, sequences the M-mode
// CSR updates through one write port, then issues a one-cycle redirect to ctrl.
module clint #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic    i_clk,
  input  logic    i_rst,
  clint_if.slave  bus
);

  localparam logic [CSR_AW-1:0] AddrMstatus = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] AddrMepc    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] AddrMcause  = CSR_AW'(12'h342);

  typedef enum logic [2:0] {
    StIdle,
    StWrMepc,
    StWrMcause,
    StWrMstatus,
    StMretMstatus,
    StAssert
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   snap_q, snap_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic              csr_wr_en_q, csr_wr_en_d;
  logic [CSR_AW-1:0] csr_wr_addr_q, csr_wr_addr_d;
  logic [XLEN-1:0]   csr_wr_data_q, csr_wr_data_d;
  logic              assert_q, assert_d;
  logic [XLEN-1:0]   assert_addr_q, assert_addr_d;

  logic            exc, irq, ret, detect, stall;
  logic [XLEN-1:0] epc_sel;
  logic            unused_bits;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1, MPP stays M.
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  always_comb begin
    exc = bus.i_x_vld & (bus.i_x_is_ecall | bus.i_x_is_ebreak);
    irq = bus.i_x_vld & bus.i_irq_timer & bus.i_csr_mstatus[3] & bus.i_csr_mie[7] &
          ~bus.i_jtag_halt;
    ret = bus.i_x_vld & bus.i_x_is_mret;
    detect  = (state_q == StIdle) & ~bus.i_bus_mem_halt & (exc | irq | ret);
    epc_sel = (!exc && bus.i_x_branch_taken) ? bus.i_x_branch_addr : bus.i_x_pc;
    stall   = detect | ((state_q != StIdle) & (state_q != StAssert));
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    snap_d        = snap_q;
    mepc_d        = mepc_q;
    csr_wr_en_d   = 1'b0;
    csr_wr_addr_d = '0;
    csr_wr_data_d = '0;
    assert_d      = 1'b0;
    assert_addr_d = '0;

    unique case (state_q)
      StIdle: begin
        if (detect) begin
          snap_d = bus.i_csr_mstatus;
          mepc_d = bus.i_csr_mepc;
          if (exc || irq) begin
            // Exceptions win over a simultaneous IRQ; the IRQ re-arms once MIE is restored.
            if (exc) begin
              cause_d = bus.i_x_is_ecall ? XLEN'(11) : XLEN'(3);
            end else begin
              cause_d = {1'b1, (XLEN-1)'(7)};
            end
            state_d       = StWrMepc;
            csr_wr_en_d   = 1'b1;
            csr_wr_addr_d = AddrMepc;
            csr_wr_data_d = {epc_sel[XLEN-1:2], 2'b00};
          end else begin
            state_d       = StMretMstatus;
            csr_wr_en_d   = 1'b1;
            csr_wr_addr_d = AddrMstatus;
            csr_wr_data_d = mret_mstatus(bus.i_csr_mstatus);
          end
        end
      end
      StWrMepc: begin
        state_d       = StWrMcause;
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = AddrMcause;
        csr_wr_data_d = cause_q;
      end
      StWrMcause: begin
        state_d       = StWrMstatus;
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = AddrMstatus;
        csr_wr_data_d = trap_mstatus(snap_q);
      end
      StWrMstatus: begin
        state_d       = StAssert;
        assert_d      = 1'b1;
        assert_addr_d = {bus.i_csr_mtvec[XLEN-1:2], 2'b00};
      end
      StMretMstatus: begin
        state_d       = StAssert;
        assert_d      = 1'b1;
        assert_addr_d = mepc_q;
      end
      StAssert: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      cause_q       <= '0;
      snap_q        <= '0;
      mepc_q        <= '0;
      csr_wr_en_q   <= 1'b0;
      csr_wr_addr_q <= '0;
      csr_wr_data_q <= '0;
      assert_q      <= 1'b0;
      assert_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      snap_q        <= snap_d;
      mepc_q        <= mepc_d;
      csr_wr_en_q   <= csr_wr_en_d;
      csr_wr_addr_q <= csr_wr_addr_d;
      csr_wr_data_q <= csr_wr_data_d;
      assert_q      <= assert_d;
      assert_addr_q <= assert_addr_d;
    end
  end

  assign bus.o_csr_wr_en         = csr_wr_en_q;
  assign bus.o_csr_wr_addr       = csr_wr_addr_q;
  assign bus.o_csr_wr_data       = csr_wr_data_q;
  assign bus.o_clint_stall       = stall;
  assign bus.o_clint_assert      = assert_q;
  assign bus.o_clint_assert_addr = assert_addr_q;

  assign unused_bits = ^{bus.i_csr_mie[XLEN-1:8], bus.i_csr_mie[6:0], bus.i_csr_mtvec[1:0],
                         epc_sel[1:0]};

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint: trap entry, mret, timer IRQ gating and async abort.
module tb_clint;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  clint_if #(.XLEN(32), .CSR_AW(12)) bus ();

  clint #(.XLEN(32), .CSR_AW(12)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_x();
    bus.i_x_vld          = 1'b0;
    bus.i_x_pc           = '0;
    bus.i_x_is_ecall     = 1'b0;
    bus.i_x_is_ebreak    = 1'b0;
    bus.i_x_is_mret      = 1'b0;
    bus.i_x_branch_taken = 1'b0;
    bus.i_x_branch_addr  = '0;
    bus.i_irq_timer      = 1'b0;
    bus.i_jtag_halt      = 1'b0;
    bus.i_bus_mem_halt   = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, ".wr_en"}, 32'(bus.o_csr_wr_en), 32'd1);
    check({tag, ".addr"}, 32'(bus.o_csr_wr_addr), addr);
    check({tag, ".data"}, bus.o_csr_wr_data, data);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".wr_en"}, 32'(bus.o_csr_wr_en), 32'd0);
    check({tag, ".stall"}, 32'(bus.o_clint_stall), 32'd0);
    check({tag, ".assert"}, 32'(bus.o_clint_assert), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    clear_x();
    bus.i_csr_mtvec   = 32'h200;
    bus.i_csr_mepc    = 32'h0;
    bus.i_csr_mstatus = 32'h8;
    bus.i_csr_mie     = 32'h80;
    #12;
    check_quiet("reset");
    check("reset.addr", 32'(bus.o_csr_wr_addr), 32'd0);
    check("reset.data", bus.o_csr_wr_data, 32'd0);
    check("reset.assert_addr", bus.o_clint_assert_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ecall at 0x100, mtvec 0x200, mstatus 0x8
    bus.i_x_vld      = 1'b1;
    bus.i_x_is_ecall = 1'b1;
    bus.i_x_pc       = 32'h100;
    #1;
    check("ecall.T.stall", 32'(bus.o_clint_stall), 32'd1);
    check("ecall.T.wr_en", 32'(bus.o_csr_wr_en), 32'd0);
    tick();
    clear_x();
    check_wr("ecall.T1", 32'h341, 32'h100);
    check("ecall.T1.stall", 32'(bus.o_clint_stall), 32'd1);
    tick();
    check_wr("ecall.T2", 32'h342, 32'd11);
    check("ecall.T2.stall", 32'(bus.o_clint_stall), 32'd1);
    tick();
    check_wr("ecall.T3", 32'h300, 32'h1880);
    check("ecall.T3.stall", 32'(bus.o_clint_stall), 32'd1);
    check("ecall.T3.assert", 32'(bus.o_clint_assert), 32'd0);
    tick();
    check("ecall.T4.assert", 32'(bus.o_clint_assert), 32'd1);
    check("ecall.T4.addr", bus.o_clint_assert_addr, 32'h200);
    check("ecall.T4.stall", 32'(bus.o_clint_stall), 32'd0);
    check("ecall.T4.wr_en", 32'(bus.o_csr_wr_en), 32'd0);
    tick();
    check_quiet("ecall.T5");

    // mret: mepc latched at T, later mepc change must not leak through
    bus.i_csr_mstatus = 32'h1880;
    bus.i_csr_mepc    = 32'h104;
    bus.i_x_vld       = 1'b1;
    bus.i_x_is_mret   = 1'b1;
    #1;
    check("mret.T.stall", 32'(bus.o_clint_stall), 32'd1);
    tick();
    clear_x();
    bus.i_csr_mepc = 32'h0;
    check_wr("mret.T1", 32'h300, 32'h1888);
    check("mret.T1.stall", 32'(bus.o_clint_stall), 32'd1);
    tick();
    check("mret.T2.assert", 32'(bus.o_clint_assert), 32'd1);
    check("mret.T2.addr", bus.o_clint_assert_addr, 32'h104);
    check("mret.T2.stall", 32'(bus.o_clint_stall), 32'd0);
    check("mret.T2.wr_en", 32'(bus.o_csr_wr_en), 32'd0);
    tick();
    check_quiet("mret.T3");

    // timer IRQ with a taken branch: epc is the branch target
    bus.i_csr_mstatus    = 32'h8;
    bus.i_irq_timer      = 1'b1;
    bus.i_x_vld          = 1'b1;
    bus.i_x_pc           = 32'h120;
    bus.i_x_branch_taken = 1'b1;
    bus.i_x_branch_addr  = 32'h300;
    #1;
    check("irq.T.stall", 32'(bus.o_clint_stall), 32'd1);
    tick();
    clear_x();
    check_wr("irq.T1", 32'h341, 32'h300);
    tick();
    check_wr("irq.T2", 32'h342, 32'h8000_0007);
    tick();
    check_wr("irq.T3", 32'h300, 32'h1880);
    tick();
    check("irq.T4.assert", 32'(bus.o_clint_assert), 32'd1);
    check("irq.T4.addr", bus.o_clint_assert_addr, 32'h200);
    tick();

    // IRQ blocked: MIE=0, then jtag halt, then no valid X instruction
    bus.i_csr_mstatus = 32'h0;
    bus.i_irq_timer   = 1'b1;
    bus.i_x_vld       = 1'b1;
    bus.i_x_pc        = 32'h130;
    #1;
    check("irq_mie0.stall", 32'(bus.o_clint_stall), 32'd0);
    tick();
    check_quiet("irq_mie0.T1");
    bus.i_csr_mstatus = 32'h8;
    bus.i_jtag_halt   = 1'b1;
    #1;
    check("irq_jtag.stall", 32'(bus.o_clint_stall), 32'd0);
    tick();
    check_quiet("irq_jtag.T1");
    bus.i_jtag_halt = 1'b0;
    bus.i_x_vld     = 1'b0;
    #1;
    check("irq_novld.stall", 32'(bus.o_clint_stall), 32'd0);
    tick();
    check_quiet("irq_novld.T1");
    clear_x();

    // bus halt defers an ecall entirely
    bus.i_bus_mem_halt = 1'b1;
    bus.i_x_vld        = 1'b1;
    bus.i_x_is_ecall   = 1'b1;
    bus.i_x_pc         = 32'h180;
    #1;
    check("memhalt.stall", 32'(bus.o_clint_stall), 32'd0);
    tick();
    check_quiet("memhalt.T1");
    clear_x();
    tick();

    // ebreak + irq same cycle -> exception wins, then async reset at T+2 aborts
    bus.i_csr_mstatus = 32'h8;
    bus.i_irq_timer   = 1'b1;
    bus.i_x_vld       = 1'b1;
    bus.i_x_is_ebreak = 1'b1;
    bus.i_x_pc        = 32'h140;
    tick();
    clear_x();
    check_wr("ebrk.T1", 32'h341, 32'h140);
    tick();
    check_wr("ebrk.T2", 32'h342, 32'd3);
    rst = 1'b1;
    #1;
    check_quiet("rst_async");
    check("rst_async.data", bus.o_csr_wr_data, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_quiet("rst_after.T3");
    tick();
    check_quiet("rst_after.T4");
    check("rst_after.assert_addr", bus.o_clint_assert_addr, 32'd0);

    // misaligned pc and mtvec are word-aligned on the way out
    bus.i_csr_mtvec  = 32'h203;
    bus.i_x_vld      = 1'b1;
    bus.i_x_is_ecall = 1'b1;
    bus.i_x_pc       = 32'h103;
    tick();
    clear_x();
    check_wr("align.T1", 32'h341, 32'h100);
    tick();
    tick();
    tick();
    check("align.T4.addr", bus.o_clint_assert_addr, 32'h200);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
